// File: rtl/lut_neuron_bank.sv
// lut_neuron_bank: NEURONS truth-table neurons in distributed RAM, zeroed by an init sweep after rst; optional readback via LUT_NEURON_BANK_READBACK_EN.
// Latency: 1 cycle from input accept to out_valid. Backpressure: out_data/out_valid hold while out_ready=0; a cfg write blocks input that cycle.
module lut_neuron_bank #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int NEURONS  = 8,
  parameter int NIDX_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NEURONS*IN_BITS-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NEURONS*OUT_BITS-1:0]  out_data,
  input  logic                         cfg_we,
  input  logic [NIDX_W-1:0]            cfg_neuron,
  input  logic [IN_BITS-1:0]           cfg_addr,
  input  logic [OUT_BITS-1:0]          cfg_wdata,
`ifdef LUT_NEURON_BANK_READBACK_EN
  input  logic                         cfg_re,
  output logic [OUT_BITS-1:0]          cfg_rdata,
  output logic                         cfg_rvalid,
`endif
  output logic                         cfg_busy
);

  localparam int DEPTH = 1 << IN_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t                      state, state_nxt;
  logic [IN_BITS-1:0]          cnt, cnt_nxt;
  logic [OUT_BITS-1:0]         mem [NEURONS][DEPTH];
  logic [NEURONS*OUT_BITS-1:0] lut;
  logic                        nidx_ok;
  logic                        cfg_hit;
  logic                        accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cfg_busy  = 1'b0;
    in_ready  = 1'b0;
    case (state)
      INIT: begin
        cfg_busy = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (&cnt) state_nxt = RUN;
      end
      RUN:     in_ready = ~cfg_we & (~out_valid | out_ready);
      default: state_nxt = INIT;
    endcase
  end

  assign nidx_ok = 32'(cfg_neuron) < NEURONS;
  assign cfg_hit = (state == RUN) & cfg_we & nidx_ok;
  assign accept  = in_valid & in_ready;

  // Table RAM has no reset port; the INIT sweep clears every neuron in parallel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        for (int n = 0; n < NEURONS; n++) mem[n][cnt] <= '0;
      end else if (cfg_hit) begin
        mem[cfg_neuron][cfg_addr] <= cfg_wdata;
      end
    end
  end

  always_comb begin
    lut = '0;
    for (int n = 0; n < NEURONS; n++)
      lut[n*OUT_BITS +: OUT_BITS] = mem[n][in_data[n*IN_BITS +: IN_BITS]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lut;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LUT_NEURON_BANK_READBACK_EN
  // Reads sample the array before any same-edge write lands, so a simultaneous write returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rvalid <= 1'b0;
      cfg_rdata  <= '0;
    end else begin
      cfg_rvalid <= cfg_re & (state == RUN);
      if (cfg_re && state == RUN)
        cfg_rdata <= nidx_ok ? mem[cfg_neuron][cfg_addr] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_lut_neuron_bank.sv
// Directed + randomized bench for lut_neuron_bank with a table-array reference model and output scoreboard.
module tb_lut_neuron_bank;

  localparam int IN_BITS  = 6;
  localparam int OUT_BITS = 1;
  localparam int NEURONS  = 8;
  localparam int NIDX_W   = 3;
  localparam int DEPTH    = 1 << IN_BITS;
  localparam int DW       = NEURONS * IN_BITS;
  localparam int OW       = NEURONS * OUT_BITS;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic              cfg_we;
  logic [NIDX_W-1:0] cfg_neuron;
  logic [IN_BITS-1:0] cfg_addr;
  logic [OUT_BITS-1:0] cfg_wdata;
  logic              cfg_busy;
`ifdef LUT_NEURON_BANK_READBACK_EN
  logic              cfg_re;
  logic [OUT_BITS-1:0] cfg_rdata;
  logic              cfg_rvalid;
`endif

  lut_neuron_bank #(
    .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .NEURONS(NEURONS), .NIDX_W(NIDX_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
`ifdef LUT_NEURON_BANK_READBACK_EN
    .cfg_re(cfg_re), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
`endif
    .cfg_busy(cfg_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit running = 1'b0;
  logic [OUT_BITS-1:0] model [NEURONS][DEPTH];
  logic [OW-1:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] ref_lookup(input logic [DW-1:0] d);
    logic [OW-1:0] r;
    for (int n = 0; n < NEURONS; n++) r[n*OUT_BITS +: OUT_BITS] = model[n][d[n*IN_BITS +: IN_BITS]];
    return r;
  endfunction

  task automatic clear_model();
    for (int n = 0; n < NEURONS; n++)
      for (int a = 0; a < DEPTH; a++) model[n][a] = '0;
  endtask

  // Observe handshakes just before the edge, update model/scoreboard, then advance one clock.
  task automatic cycle();
    logic [OW-1:0] e;
    #1;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e));
      end
    end
    if (in_valid && in_ready) sb.push_back(ref_lookup(in_data));
    if (running && cfg_we && 32'(cfg_neuron) < NEURONS) model[cfg_neuron][cfg_addr] = cfg_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic init_sweep(input string tag);
    int bad = 0;
    int rv  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cfg_busy !== 1'b1 || in_ready !== 1'b0) bad++;
`ifdef LUT_NEURON_BANK_READBACK_EN
      if (cfg_rvalid !== 1'b0) rv++;
`endif
      cycle();
    end
`ifdef LUT_NEURON_BANK_READBACK_EN
    if (cfg_rvalid !== 1'b0) rv++;
    chk({tag, "_rvalid_in_init"}, 64'(rv), 64'd0);
`endif
    chk({tag, "_busy_cycles"}, 64'(bad), 64'd0);
    chk({tag, "_busy_done"}, 64'(cfg_busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int wn, wa;
    logic [OW-1:0] held;
    logic [OUT_BITS-1:0] wv;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_wdata = '0;
`ifdef LUT_NEURON_BANK_READBACK_EN
    cfg_re = 1'b0;
`endif
    clear_model();

    // Reset held for two cycles.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_cfg_busy", 64'(cfg_busy), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef LUT_NEURON_BANK_READBACK_EN
    chk("rst_rvalid", 64'(cfg_rvalid), 64'd0);
    chk("rst_rdata", 64'(cfg_rdata), 64'd0);
    cfg_re = 1'b1;
`endif
    rst = 1'b0;
    in_valid = 1'b1;
    init_sweep("init1");
    in_valid = 1'b0;
`ifdef LUT_NEURON_BANK_READBACK_EN
    cfg_re = 1'b0;
`endif
    running = 1'b1;

    // All-zero lookup after init.
    in_valid = 1'b1; in_data = '0; #1;
    chk("ready_after_init", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0;
    chk("zero_valid", 64'(out_valid), 64'd1);
    chk("zero_data", 64'(out_data), 64'd0);

    // Load two entries and look them up.
    cfg_we = 1'b1; cfg_neuron = 3'd0; cfg_addr = 6'b011000; cfg_wdata = 1'b1;
    cycle();
    cfg_neuron = 3'd3; cfg_addr = 6'b000001;
    cycle();
    cfg_we = 1'b0;
    in_data = '0;
    in_data[0*IN_BITS +: IN_BITS] = 6'b011000;
    in_data[3*IN_BITS +: IN_BITS] = 6'b000001;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("load_valid", 64'(out_valid), 64'd1);
    chk("load_data", 64'(out_data), 64'b00001001);

    // Back-pressure: result must hold for 10 cycles.
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'({$urandom, $urandom});
    held = out_data;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) bad++;
    end
    chk("bp_hold_cycles", 64'(bad), 64'd0);
    chk("bp_held_data", 64'(held), 64'b00001001);

    // Release: one result per cycle.
    out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_data = DW'({$urandom, $urandom}); #1;
      if (in_ready !== 1'b1) bad++;
      cycle();
      if (out_valid !== 1'b1) bad++;
    end
    chk("stream_full_rate", 64'(bad), 64'd0);
    in_valid = 1'b0;
    cycle();

    // Random table contents.
    cfg_we = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cfg_neuron = NIDX_W'($urandom); cfg_addr = IN_BITS'($urandom); cfg_wdata = OUT_BITS'($urandom);
      cycle();
    end
    cfg_we = 1'b0;

    // Write collision: write wins, lookup next cycle sees the new value.
    wn = $urandom_range(0, NEURONS - 1); wa = $urandom_range(0, DEPTH - 1);
    wv = ~model[wn][wa];
    cfg_we = 1'b1; cfg_neuron = NIDX_W'(wn); cfg_addr = IN_BITS'(wa); cfg_wdata = wv;
    in_valid = 1'b1; in_data = DW'({$urandom, $urandom});
    in_data[wn*IN_BITS +: IN_BITS] = IN_BITS'(wa);
    #1;
    chk("collide_ready", 64'(in_ready), 64'd0);
    cycle();
    cfg_we = 1'b0;
    cycle();
    in_valid = 1'b0;
    chk("collide_valid", 64'(out_valid), 64'd1);
    chk("collide_new_value", 64'(out_data[wn*OUT_BITS +: OUT_BITS]), 64'(wv));

    // Randomized mixed traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      in_data = DW'({$urandom, $urandom});
      cfg_we = ($urandom_range(0, 4) == 0);
      cfg_neuron = NIDX_W'($urandom); cfg_addr = IN_BITS'($urandom); cfg_wdata = OUT_BITS'($urandom);
      cycle();
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    cycle();
    cycle();
    chk("sb_drained", 64'(sb.size()), 64'd0);

`ifdef LUT_NEURON_BANK_READBACK_EN
    cfg_we = 1'b1; cfg_neuron = 3'd7; cfg_addr = 6'd63; cfg_wdata = 1'b1;
    cycle();
    cfg_we = 1'b0; cfg_re = 1'b1;
    cycle();
    cfg_re = 1'b0;
    chk("rb_rvalid", 64'(cfg_rvalid), 64'd1);
    chk("rb_rdata", 64'(cfg_rdata), 64'(model[7][63]));
    cycle();
    chk("rb_rvalid_pulse", 64'(cfg_rvalid), 64'd0);
    wv = ~model[2][5];
    cfg_we = 1'b1; cfg_re = 1'b1; cfg_neuron = 3'd2; cfg_addr = 6'd5; cfg_wdata = wv;
    cycle();
    cfg_we = 1'b0; cfg_re = 1'b0;
    chk("rb_prewrite", 64'(cfg_rdata), 64'(~wv));
`endif

    // Reset mid-stream with a loaded table and a pending result.
    cfg_we = 1'b1; cfg_neuron = 3'd0; cfg_addr = 6'b011000; cfg_wdata = 1'b1;
    cycle();
    cfg_neuron = 3'd3; cfg_addr = 6'b000001;
    cycle();
    cfg_we = 1'b0;
    in_data = '0;
    in_data[0*IN_BITS +: IN_BITS] = 6'b011000;
    in_data[3*IN_BITS +: IN_BITS] = 6'b000001;
    in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_data", 64'(out_data), 64'b00001001);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sb.delete();
    clear_model();
    running = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(cfg_busy), 64'd1);
    // Writes during INIT must be dropped.
    cfg_we = 1'b1; cfg_neuron = 3'd0; cfg_addr = 6'b011000; cfg_wdata = 1'b1;
`ifdef LUT_NEURON_BANK_READBACK_EN
    cfg_re = 1'b1;
`endif
    init_sweep("init2");
    cfg_we = 1'b0;
`ifdef LUT_NEURON_BANK_READBACK_EN
    cfg_re = 1'b0;
`endif
    running = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("postrst_valid", 64'(out_valid), 64'd1);
    chk("postrst_zeroed", 64'(out_data), 64'd0);
    cycle();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
